// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for the whole bus cycle.
// A slave-response watchdog terminates hung cycles with an error to the owning master.
module wb_arbiter2 #(
  parameter int adr_width = 32,
  parameter int dat_width = 32,
  parameter int timeout   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_cyc,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  input  logic [dat_width/8-1:0] m0_sel,
  input  logic [adr_width-1:0]   m0_adr,
  input  logic [dat_width-1:0]   m0_dat_w,
  output logic [dat_width-1:0]   m0_dat_r,
  output logic                   m0_ack,
  output logic                   m0_err,
  input  logic                   m1_cyc,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  input  logic [dat_width/8-1:0] m1_sel,
  input  logic [adr_width-1:0]   m1_adr,
  input  logic [dat_width-1:0]   m1_dat_w,
  output logic [dat_width-1:0]   m1_dat_r,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [dat_width/8-1:0] s_sel,
  output logic [adr_width-1:0]   s_adr,
  output logic [dat_width-1:0]   s_dat_w,
  input  logic [dat_width-1:0]   s_dat_r,
  input  logic                   s_ack,
  input  logic                   s_err,
  output logic [1:0]             grant,
  output logic                   timeout_evt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [15:0] TMO = 16'(timeout);

  state_t      state;
  logic        last;
  logic [15:0] wcnt;
  logic        gnt0, gnt1;
  logic        sel_cyc, sel_stb;
  logic        at_limit, fire;
  logic [15:0] wcnt_run;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  assign sel_cyc = (gnt0 & m0_cyc) | (gnt1 & m1_cyc);
  assign sel_stb = (gnt0 & m0_stb) | (gnt1 & m1_stb);

  // The stall gate does not look at s_ack, so a slave that acks combinationally
  // from s_stb cannot form a loop through the arbiter; ack still suppresses the error.
  assign at_limit = (TMO != 16'd0) && sel_cyc && sel_stb && (wcnt == TMO);
  assign fire     = at_limit & ~s_ack & ~s_err;

  assign s_cyc   = sel_cyc & ~at_limit;
  assign s_stb   = sel_stb & ~at_limit;
  assign s_we    = gnt1 ? m1_we    : m0_we;
  assign s_sel   = gnt1 ? m1_sel   : m0_sel;
  assign s_adr   = gnt1 ? m1_adr   : m0_adr;
  assign s_dat_w = gnt1 ? m1_dat_w : m0_dat_w;

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = gnt0 & s_ack;
  assign m1_ack   = gnt1 & s_ack;
  assign m0_err   = gnt0 & (s_err | fire);
  assign m1_err   = gnt1 & (s_err | fire);

  assign grant       = {gnt1, gnt0};
  assign timeout_evt = fire;

  assign wcnt_run = (s_ack | s_err | fire) ? 16'd0 :
                    (sel_cyc & sel_stb)    ? wcnt + 16'd1 : wcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      wcnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          wcnt <= 16'd0;
          if (m0_cyc && m1_cyc) state <= last ? GNT0 : GNT1;
          else if (m0_cyc)      state <= GNT0;
          else if (m1_cyc)      state <= GNT1;
        end
        GNT0: begin
          if (!m0_cyc) begin
            last  <= 1'b0;
            wcnt  <= 16'd0;
            state <= m1_cyc ? GNT1 : IDLE;
          end else begin
            wcnt <= wcnt_run;
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            last  <= 1'b1;
            wcnt  <= 16'd0;
            state <= m0_cyc ? GNT0 : IDLE;
          end else begin
            wcnt <= wcnt_run;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus a randomized run
// compared against an owner/last/wait-count model of the arbitration rules.
module tb_wb_arbiter2;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic        s_ack, s_err;
  logic [1:0]  grant;
  logic        timeout_evt;

  int checks = 0;
  int errors = 0;

  wb_arbiter2 #(.adr_width(32), .dat_width(32), .timeout(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
    .s_ack(s_ack), .s_err(s_err),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen a unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hf; m0_adr = 32'h0; m0_dat_w = 32'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hf; m1_adr = 32'h0; m1_dat_w = 32'h0;
    s_dat_r = 32'h0; s_ack = 0; s_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #3;
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || timeout_evt !== 1'b0 ||
        m0_ack !== 1'b0 || m0_err !== 1'b0 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got grant=%b s_cyc=%b s_stb=%b evt=%b acks=%b%b errs=%b%b, want all zero",
               grant, s_cyc, s_stb, timeout_evt, m0_ack, m1_ack, m0_err, m1_err);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("[TB] FAIL read_grant_latency: got %b want 00", grant);
    end
    tick(); #1;
    checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b1 || s_adr !== 32'h100) begin
      errors++; $display("[TB] FAIL read_granted: got grant=%b s_cyc=%b s_adr=%h want 01 1 00000100", grant, s_cyc, s_adr);
    end
    tick();
    s_ack = 1; s_dat_r = 32'hcafe_f00d;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_dat_r !== 32'hcafe_f00d || m1_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL read_ack: got m0_ack=%b m0_dat_r=%h m1_ack=%b want 1 cafef00d 0", m0_ack, m0_dat_r, m1_ack);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_alternation();
    int lst;
    int w, o;
    do_reset();
    lst = 1;
    for (int r = 0; r < 4; r++) begin
      w = (lst == 1) ? 0 : 1;
      o = 1 - w;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick(); #1;
      checks++;
      if (grant !== 2'(1 << w)) begin
        errors++; $display("[TB] FAIL alt_winner round %0d: got %b want %b", r, grant, 2'(1 << w));
      end
      if (r % 2 == 0) begin
        if (w == 0) m0_cyc = 0; else m1_cyc = 0;
        tick(); #1;
        checks++;
        if (grant !== 2'(1 << o) || s_cyc !== 1'b1) begin
          errors++; $display("[TB] FAIL alt_handover round %0d: got grant=%b s_cyc=%b want %b 1", r, grant, s_cyc, 2'(1 << o));
        end
        m0_cyc = 0; m1_cyc = 0;
        lst = o;
      end else begin
        m0_cyc = 0; m1_cyc = 0;
        lst = w;
      end
      tick(); #1;
      checks++;
      if (grant !== 2'b00) begin
        errors++; $display("[TB] FAIL alt_idle round %0d: got %b want 00", r, grant);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      s_ack = 1; s_dat_r = 32'h1000 + k;
      #1;
      checks++;
      if (grant !== 2'b10 || m1_ack !== 1'b1 || m0_ack !== 1'b0 || s_adr !== 32'h200) begin
        errors++; $display("[TB] FAIL b2b_hold strobe %0d: got grant=%b m1_ack=%b m0_ack=%b s_adr=%h want 10 1 0 00000200",
                           k, grant, m1_ack, m0_ack, s_adr);
      end
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick(); #1;
    checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b1 || s_adr !== 32'h300) begin
      errors++; $display("[TB] FAIL b2b_handover: got grant=%b s_cyc=%b s_adr=%h want 01 1 00000300", grant, s_cyc, s_adr);
    end
    tick();
    idle_inputs();
  endtask

  task automatic run_watchdog(input bit ack_last);
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    tick();
    for (int k = 1; k <= TMO + 1; k++) begin
      if (k == TMO + 1 && ack_last) s_ack = 1;
      #1;
      checks++;
      if (k <= TMO) begin
        if (m1_err !== 1'b0 || timeout_evt !== 1'b0 || s_stb !== 1'b1) begin
          errors++; $display("[TB] FAIL wd_wait cycle %0d: got err=%b evt=%b s_stb=%b want 0 0 1", k, m1_err, timeout_evt, s_stb);
        end
      end else if (!ack_last) begin
        if (m1_err !== 1'b1 || timeout_evt !== 1'b1 || s_stb !== 1'b0 || s_cyc !== 1'b0 || grant !== 2'b10) begin
          errors++; $display("[TB] FAIL wd_fire: got err=%b evt=%b s_stb=%b s_cyc=%b grant=%b want 1 1 0 0 10",
                             m1_err, timeout_evt, s_stb, s_cyc, grant);
        end
      end else begin
        if (m1_ack !== 1'b1 || m1_err !== 1'b0 || timeout_evt !== 1'b0) begin
          errors++; $display("[TB] FAIL wd_ack_wins: got ack=%b err=%b evt=%b want 1 0 0", m1_ack, m1_err, timeout_evt);
        end
      end
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick(); #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("[TB] FAIL wd_release: got grant=%b want 00", grant);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    run_watchdog(1'b0);
  endtask

  task automatic test_ack_precedence();
    run_watchdog(1'b1);
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    tick();
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_err = 0;
    #1;
    checks++;
    if (grant !== 2'b10 || m1_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL arst_setup: got grant=%b m1_ack=%b want 10 1", grant, m1_ack);
    end
    #1;
    rst = 1;
    #1;
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 ||
        m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_err !== 1'b0 || m1_err !== 1'b0) begin
      errors++; $display("[TB] FAIL arst_drop: got grant=%b s_cyc=%b s_stb=%b acks=%b%b errs=%b%b want all zero",
                         grant, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err);
    end
    tick();
    s_ack = 0;
    rst = 0;
    tick(); #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("[TB] FAIL arst_m0_first: got grant=%b want 01", grant);
    end
    idle_inputs();
  endtask

  // Model: owner is -1 (none), 0 or 1; lst is the last master served; wt counts unanswered strobed cycles.
  task automatic test_random();
    int owner, lst, wt, nowner;
    bit rc, rs, lim, fr, cy0, cy1;
    logic [1:0] eg;
    logic [31:0] ea;
    do_reset();
    owner = -1; lst = 1; wt = 0;
    for (int n = 0; n < 600; n++) begin
      m0_cyc = m0_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m1_cyc = m1_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m0_stb = m0_cyc & ($urandom_range(0, 4) != 0);
      m1_stb = m1_cyc & ($urandom_range(0, 4) != 0);
      m0_adr = $urandom; m1_adr = $urandom; s_dat_r = $urandom;
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      s_ack = (n < 250) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0);
      s_err = ($urandom_range(0, 19) == 0);
      cy0 = m0_cyc; cy1 = m1_cyc;
      rc  = (owner == 0) ? cy0 : (owner == 1) ? cy1 : 1'b0;
      rs  = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
      lim = rc && rs && (wt == TMO);
      fr  = lim && !s_ack && !s_err;
      eg  = (owner < 0) ? 2'b00 : 2'(1 << owner);
      ea  = (owner == 1) ? m1_adr : m0_adr;
      #1;
      checks++;
      if (grant !== eg || m0_ack !== (owner == 0 && s_ack) || m1_ack !== (owner == 1 && s_ack) ||
          m0_err !== (owner == 0 && (s_err || fr)) || m1_err !== (owner == 1 && (s_err || fr)) ||
          timeout_evt !== fr || s_adr !== ea || m0_dat_r !== s_dat_r || m1_dat_r !== s_dat_r ||
          (!(lim && s_ack) && s_cyc !== (rc && !lim))) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got grant=%b ack=%b%b err=%b%b evt=%b s_cyc=%b; want grant=%b ack=%b%b err=%b%b evt=%b s_cyc=%b",
                 n, grant, m1_ack, m0_ack, m1_err, m0_err, timeout_evt, s_cyc,
                 eg, (owner == 1 && s_ack), (owner == 0 && s_ack),
                 (owner == 1 && (s_err || fr)), (owner == 0 && (s_err || fr)), fr, (rc && !lim));
      end
      if (owner < 0) begin
        if (cy0 && cy1) nowner = (lst == 1) ? 0 : 1;
        else if (cy0)   nowner = 0;
        else if (cy1)   nowner = 1;
        else            nowner = -1;
      end else if ((owner == 0) ? cy0 : cy1) begin
        nowner = owner;
      end else begin
        lst = owner;
        nowner = ((owner == 0) ? cy1 : cy0) ? 1 - owner : -1;
      end
      if (owner < 0 || nowner != owner || s_ack || s_err || fr) wt = 0;
      else if (rc && rs) wt++;
      owner = nowner;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternation();
    test_back_to_back();
    test_timeout();
    test_ack_precedence();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone arbiter that shares the system's single slave bus (memory, UART, timer, GPIO decoders) between the LM32 instruction master (m0) and data master (m1). Round-robin grant, held for the whole bus cycle (`cyc`). A slave-response watchdog terminates hung cycles with an error. It sits between the CPU bus ports and the address decoder in `system`.

## Interface
- `adr_width`, 32, address width.
- `dat_width`, 32, data width; `sel` is `dat_width/8` bits.
- `timeout`, 255, maximum wait cycles for `ack`/`err` (16-bit counter, 0 disables the watchdog).

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 cycle, strobe, write.
- `m0_sel`  in  dat_width/8  byte selects.
- `m0_adr`  in  adr_width  address.
- `m0_dat_w`  in  dat_width  write data.
- `m0_dat_r`  out  dat_width  read data.
- `m0_ack`, `m0_err`  out  1 each  termination.
- `m1_*`  same set as `m0_*`, for master 1.
- `s_cyc`, `s_stb`, `s_we`, `s_sel`, `s_adr`, `s_dat_w`  out  slave request, widths as above.
- `s_dat_r`  in  dat_width  slave read data.
- `s_ack`, `s_err`  in  1 each  slave termination.
- `grant`  out  2  one-hot current owner (bit0 = m0, bit1 = m1), `00` when idle.
- `timeout_evt`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, GNT0, GNT1. A register `last` holds the last-served master.
- IDLE:
  - Only `m0_cyc` high → GNT0.
  - Only `m1_cyc` high → GNT1.
  - Both high → grant the master that is not `last`.
  - Neither high → stay in IDLE.
- GNTx, `mx_cyc` high → stay in GNTx.
- GNTx, `mx_cyc` low:
  - Other master's `cyc` high → go directly to GNT(other).
  - Otherwise → IDLE.
  - `last` ← x on leaving GNTx.
- Slave outputs:
  - In GNTx, all `s_*` request outputs are combinationally muxed from master x.
  - In IDLE, `s_cyc` = `s_stb` = 0; the other request fields are don't-care and driven from m0.
- Responses:
  - `s_ack` and `s_err` are routed combinationally to the granted master only.
  - The non-granted master sees `ack` = `err` = 0.
  - `s_dat_r` is broadcast to both `mx_dat_r`.
- Watchdog counter `wcnt`:
  - Increments each cycle with `s_cyc & s_stb & ~s_ack & ~s_err`.
  - Clears on `s_ack`, on `s_err`, on any grant change, and in IDLE.
  - When `wcnt == timeout` (with `timeout != 0`), in that same cycle:
    - granted `mx_err` = 1;
    - `s_cyc` and `s_stb` are forced to 0;
    - `timeout_evt` = 1;
    - `wcnt` clears at the next edge.
  - Grant is retained; the master is expected to drop `cyc`.
- A slave `ack` in the same cycle the watchdog would fire takes precedence: normal `ack`, no `err`, no event.

## Timing
- Reset values (asynchronous):
  - state IDLE, `last` = 1 (so m0 wins the first contention), `wcnt` = 0;
  - `grant` = 00, `s_cyc` = `s_stb` = 0, all `mx_ack` / `mx_err` = 0, `timeout_evt` = 0.
- Reset asserted mid-cycle: every output above drops immediately, without waiting for a clock edge.
- Arbitration latency: `cyc` rising in cycle N gives `grant` and `s_cyc` high in cycle N+1.
- Owner handover with the other master waiting: owner drops `cyc` in cycle N, the new owner drives the slave in cycle N+1. There is no idle bubble.
- Data path: zero added latency. `ack`/`err`/`dat_r` are combinational pass-through, so single-cycle slave acks are preserved.
- Watchdog: with `s_stb` held and no response, `err` is asserted in wait cycle `timeout`+1, counting the first strobed cycle as 1.
- Simultaneous requests in IDLE are resolved purely by `last`. A master re-requesting in the cycle its grant is released does not win if the other master is requesting.

## Test plan
- Reset, then `m0_cyc`/`m0_stb` read at 0x100, slave acks after 2 cycles → `grant` = 01 one cycle after `cyc`; `m0_ack` in the ack cycle with `m0_dat_r` = slave data; `m1_ack` = 0 throughout.
- `m0_cyc` and `m1_cyc` rise in the same cycle after reset → m0 granted first. On m0 release, m1 is granted the next cycle. On the next simultaneous request, m0 wins again (alternation over 4 rounds).
- m1 holds `cyc` over 3 back-to-back acked strobes while m0 requests → `grant` stays 10 until `m1_cyc` falls; m0 then owns the slave with no idle cycle.
- `timeout` = 8, m1 strobes, slave never responds → `m1_err` and `timeout_evt` high exactly in wait cycle 9, `s_stb` low that cycle. m1 drops `cyc` → IDLE.
- Same setup, slave acks in wait cycle 9 → `m1_ack` = 1, `m1_err` = 0, no `timeout_evt`.
- Assert `rst` while GNT1 is active → `grant`, `s_cyc`, `s_stb`, `mx_ack`, `mx_err` drop asynchronously. After release, a pending `m0_cyc` is granted first.
